// File: rtl/alu_input_sequencer.sv
// Captures operand A, operand B and opcode from switches on successive debounced button presses.
// Capture lands DB_CYCLES+2 edges after the button is first sampled high; i_clr overrides any press.
module alu_input_sequencer #(
  parameter int NB_DATA   = 6,
  parameter int NB_OP     = 6,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic               i_btn,
  input  logic               i_clr,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [1:0]         o_state,
  output logic               o_valid,
  output logic               o_start
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_SHOW = 2'b11
  } state_e;

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic             press;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               start_q, start_d;
  logic [NB_OP-1:0]   sw_op;

  // Opcode is taken from the low switch bits, or zero-padded when wider than the switches.
  if (NB_OP <= NB_DATA) begin : g_op_trunc
    assign sw_op = i_sw[NB_OP-1:0];
  end else begin : g_op_ext
    assign sw_op = {{(NB_OP - NB_DATA){1'b0}}, i_sw};
  end

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Press is a registered rising edge of the debounced level, so release does nothing.
  assign press = deb_q & ~deb_prev_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      sync1_q    <= i_btn;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    op_d     = op_q;
    start_d  = 1'b0;
    if (i_clr) begin
      state_d  = S_A;
      data_a_d = '0;
      data_b_d = '0;
      op_d     = '0;
    end else if (press) begin
      case (state_q)
        S_A: begin
          data_a_d = i_sw;
          state_d  = S_B;
        end
        S_B: begin
          data_b_d = i_sw;
          state_d  = S_OP;
        end
        S_OP: begin
          op_d    = sw_op;
          state_d = S_SHOW;
          start_d = 1'b1;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_A;
      data_a_q <= '0;
      data_b_q <= '0;
      op_q     <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      op_q     <= op_d;
      start_q  <= start_d;
    end
  end

  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;
  assign o_op     = op_q;
  assign o_state  = state_q;
  assign o_valid  = (state_q == S_SHOW);
  assign o_start  = start_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer: directed scenarios followed by random button/switch/clear traffic,
// all compared every cycle against a sample-window reference model.
module tb_alu_input_sequencer;

  localparam int NB_DATA = 6;
  localparam int NB_OP   = 6;
  localparam int DB      = 4;
  localparam int LAT     = DB + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NB_DATA-1:0] sw;
  logic               btn;
  logic               clr;
  logic [NB_DATA-1:0] data_a;
  logic [NB_DATA-1:0] data_b;
  logic [NB_OP-1:0]   op;
  logic [1:0]         state;
  logic               valid;
  logic               start;

  int checks = 0;
  int errors = 0;

  alu_input_sequencer #(
    .NB_DATA  (NB_DATA),
    .NB_OP    (NB_OP),
    .DB_CYCLES(DB)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_sw    (sw),
    .i_btn   (btn),
    .i_clr   (clr),
    .o_data_a(data_a),
    .o_data_b(data_b),
    .o_op    (op),
    .o_state (state),
    .o_valid (valid),
    .o_start (start)
  );

  always #5 clk = ~clk;

  // Reference: history of raw button samples; the debounced level flips once the last DB
  // synchronized samples (raw samples two edges old) all disagree with it.
  bit               hist[$];
  bit               m_deb;
  bit               m_deb_prev;
  int               m_idx;
  logic [NB_DATA-1:0] m_reg[3];
  bit               m_start;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
    m_deb      = 1'b0;
    m_deb_prev = 1'b0;
    m_idx      = 0;
    for (int i = 0; i < 3; i++) m_reg[i] = '0;
    m_start    = 1'b0;
  endfunction

  function automatic void model_edge(bit b, logic [NB_DATA-1:0] s, bit c);
    bit press;
    bit all_diff;
    press    = m_deb && !m_deb_prev;
    all_diff = 1'b1;
    for (int k = 1; k <= DB; k++)
      if (hist[hist.size() - 1 - k] == m_deb) all_diff = 1'b0;
    m_start = 1'b0;
    if (c) begin
      m_idx = 0;
      for (int i = 0; i < 3; i++) m_reg[i] = '0;
    end else if (press) begin
      if (m_idx < 3) m_reg[m_idx] = s;
      m_start = (m_idx == 2);
      m_idx   = (m_idx + 1) % 4;
    end
    m_deb_prev = m_deb;
    if (all_diff) m_deb = !m_deb;
    hist.push_back(b);
    void'(hist.pop_front());
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_idx));
    chk("data_a", 32'(data_a), 32'(m_reg[0]));
    chk("data_b", 32'(data_b), 32'(m_reg[1]));
    chk("op", 32'(op), 32'(m_reg[2]));
    chk("valid", 32'(valid), 32'(m_idx == 3));
    chk("start", 32'(start), 32'(m_start));
  endtask

  // Entered and left on a falling edge; inputs change away from the rising edge.
  task automatic tick(bit b, logic [NB_DATA-1:0] s, bit c, bit r);
    btn = b; sw = s; clr = c; rst = r;
    if (r) model_reset();
    @(posedge clk);
    if (!r) model_edge(b, s, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic release_btn(int n);
    for (int i = 0; i < n; i++) tick(1'b0, NB_DATA'($urandom), 1'b0, 1'b0);
  endtask

  // Holds the button with a fixed switch value and checks the edges from onset to capture.
  task automatic press_measure(logic [NB_DATA-1:0] s, string tag);
    logic [1:0] st0;
    int         n;
    bit         seen;
    st0  = state;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1'b1, s, 1'b0, 1'b0);
      n++;
      if (state != st0) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n - 1), 32'(LAT));
  endtask

  initial begin
    int changes;
    logic [1:0] prev_st;
    btn = 1'b0; sw = '0; clr = 1'b0; rst = 1'b1;
    model_reset();
    @(negedge clk);
    tick(1'b0, 6'd0, 1'b0, 1'b1);
    tick(1'b1, 6'd21, 1'b0, 1'b1);
    release_btn(3);

    // Three clean presses A, B, OP.
    press_measure(6'd5, "press_a");
    release_btn(10);
    press_measure(6'd9, "press_b");
    release_btn(10);
    press_measure(6'd0, "press_op");
    chk("show_start", 32'(start), 32'd1);
    chk("show_state", 32'(state), 32'd3);
    release_btn(10);
    chk("show_a", 32'(data_a), 32'd5);
    chk("show_b", 32'(data_b), 32'd9);
    chk("show_valid", 32'(valid), 32'd1);

    // Fourth press returns to A with operands held.
    press_measure(6'd7, "press_show");
    chk("wrap_a_held", 32'(data_a), 32'd5);
    chk("wrap_valid", 32'(valid), 32'd0);
    release_btn(10);

    // Short glitch: no press, counter back to idle.
    for (int i = 0; i < DB - 1; i++) tick(1'b1, 6'd33, 1'b0, 1'b0);
    release_btn(10);
    chk("glitch_state", 32'(state), 32'd0);
    chk("glitch_cnt", 32'(dut.cnt_q), 32'd0);

    // Long hold gives one press only.
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      prev_st = state;
      tick(1'b1, 6'd44, 1'b0, 1'b0);
      if (state != prev_st) changes++;
    end
    chk("hold_changes", 32'(changes), 32'd1);
    chk("hold_state", 32'(state), 32'd1);
    release_btn(10);

    // Clear coincident with the B capture edge.
    for (int i = 0; i < LAT; i++) tick(1'b1, 6'd33, 1'b0, 1'b0);
    tick(1'b1, 6'd33, 1'b1, 1'b0);
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_b", 32'(data_b), 32'd0);
    chk("clr_a", 32'(data_a), 32'd0);
    release_btn(10);

    // Reset mid-debounce, button still held, then a full-latency press.
    for (int i = 0; i < 4; i++) tick(1'b1, 6'd17, 1'b0, 1'b0);
    chk("mid_cnt", 32'(dut.cnt_q), 32'd2);
    tick(1'b1, 6'd17, 1'b0, 1'b1);
    tick(1'b1, 6'd17, 1'b0, 1'b1);
    chk("rst_state", 32'(state), 32'd0);
    press_measure(6'd17, "post_rst");
    chk("post_rst_a", 32'(data_a), 32'd17);
    release_btn(10);

    // Random traffic with occasional clears.
    for (int it = 0; it < 60; it++) begin
      int hi;
      int lo;
      logic [NB_DATA-1:0] s;
      hi = $urandom_range(12, 1);
      lo = $urandom_range(12, 1);
      s  = NB_DATA'($urandom);
      for (int i = 0; i < hi; i++) tick(1'b1, s, ($urandom_range(19, 0) == 0), 1'b0);
      for (int i = 0; i < lo; i++) tick(1'b0, NB_DATA'($urandom), ($urandom_range(19, 0) == 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_input_sequencer.md
ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 Parameter NB_DATA, default 6, switch and operand width in bits.
REQ-002 Parameter NB_OP, default 6, opcode width in bits.
REQ-003 Parameter DB_CYCLES, default 1_000_000, debounce stability window in clock cycles; minimum 2.
REQ-004 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_sw  input  NB_DATA  switch value to be captured.
REQ-007 i_btn  input  1  raw, asynchronous, bouncing load button.
REQ-008 i_clr  input  1  synchronous clear, active-high, already clean.
REQ-009 o_data_a  output  NB_DATA  registered operand A to the ALU.
REQ-010 o_data_b  output  NB_DATA  registered operand B to the ALU.
REQ-011 o_op  output  NB_OP  registered opcode to the ALU.
REQ-012 o_state  output  2  current FSM state encoding.
REQ-013 o_valid  output  1  high while A, B and OP form a complete set.
REQ-014 o_start  output  1  one-cycle pulse when a complete set becomes valid.

Function
REQ-015 i_btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Debouncer counter SHALL increment each cycle the synchronized level differs from the debounced level, and reset to 0 when they are equal.
REQ-017 Debounced level SHALL take the synchronized value, and the counter SHALL reset to 0, on the edge at which the counter equals DB_CYCLES-1 and the levels still differ.
REQ-018 A press event SHALL be a 0->1 transition of the debounced level; a 1->0 transition SHALL cause no action.
REQ-019 Press latency: capture SHALL occur exactly DB_CYCLES+2 rising edges after the first edge that samples i_btn high, provided i_btn stays high throughout.
REQ-020 FSM states: S_A=2'b00, S_B=2'b01, S_OP=2'b10, S_SHOW=2'b11; o_state SHALL equal the current state.
REQ-021 In S_A, a press SHALL load i_sw into o_data_a and move to S_B.
REQ-022 In S_B, a press SHALL load i_sw into o_data_b and move to S_OP.
REQ-023 In S_OP, a press SHALL load i_sw into o_op and move to S_SHOW. The value SHALL be truncated to the low NB_OP bits if NB_OP<NB_DATA, and zero-extended if NB_OP>NB_DATA.
REQ-024 In S_SHOW, a press SHALL move to S_A and clear o_valid; operand and opcode registers SHALL hold until overwritten.
REQ-025 o_valid SHALL be 1 exactly while state is S_SHOW.
REQ-026 o_start SHALL be high for exactly the one cycle following the S_OP->S_SHOW transition edge.
REQ-027 i_clr high SHALL, on the next edge, force S_A, zero o_data_a, o_data_b and o_op, and clear o_valid and o_start.
REQ-028 When i_clr and a press event coincide, i_clr SHALL win and the press SHALL be discarded.
REQ-029 Holding i_btn high SHALL yield exactly one press; a new press SHALL require the debounced level to return to 0 first.
REQ-030 Bounce pulses shorter than DB_CYCLES cycles SHALL cause no press and no state change.

Reset
REQ-031 While i_rst is high, all registers SHALL be asynchronously forced as follows: state S_A, o_data_a/o_data_b/o_op 0, o_valid 0, o_start 0, synchronizer flops 0, debounced level 0, counter 0.
REQ-032 Reset asserted mid-sequence, including during a debounce count, SHALL abort the sequence; no capture SHALL occur from the interrupted press after release.
REQ-033 After i_rst deasserts, a button held high SHALL register as a new press after the full REQ-019 latency.

Verification (DB_CYCLES=4, NB_DATA=NB_OP=6)
REQ-034 Three clean presses with i_sw=5, 9, 0 -> o_data_a=5, o_data_b=9, o_op=0, state 11, o_valid=1, o_start high for 1 cycle; each capture 6 edges after press onset.
REQ-035 i_btn glitch of 3 high cycles, then low -> no capture, o_state stays 00, counter returns to 0.
REQ-036 i_btn held high for 100 cycles in S_A -> exactly one capture, state 01.
REQ-037 Fourth press from S_SHOW -> state 00, o_valid=0; o_data_a still 5 until the next press loads a new value.
REQ-038 i_clr pulsed on the same cycle a press completes in S_B -> state 00, all operands 0, o_data_b not loaded.
REQ-039 i_rst asserted at debounce count 2 with the button still held, then released -> outputs 0, state 00, then one capture exactly 6 edges after reset release.
